// File: rtl/gcd_scheduler_if.sv
// Requester and core-side signal bundle for gcd_scheduler.
//   slave  : scheduler view (requests, operands, core completion in;
//            ack/done/result/err/busy and core control out)
//   master : environment view (requesters plus GCD core), directions mirrored
interface gcd_scheduler_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 16
);
  logic [N_REQ-1:0]       req_i;
  logic [N_REQ*WIDTH-1:0] a_i;
  logic [N_REQ*WIDTH-1:0] b_i;
  logic [N_REQ-1:0]       ack_o;
  logic [N_REQ-1:0]       done_o;
  logic [WIDTH-1:0]       result_o;
  logic                   err_o;
  logic                   busy_o;
  logic                   core_start_o;
  logic [WIDTH-1:0]       core_a_o;
  logic [WIDTH-1:0]       core_b_o;
  logic                   core_abort_o;
  logic                   core_done_i;
  logic [WIDTH-1:0]       core_result_i;

  modport slave (
    input  req_i, a_i, b_i, core_done_i, core_result_i,
    output ack_o, done_o, result_o, err_o, busy_o,
           core_start_o, core_a_o, core_b_o, core_abort_o
  );

  modport master (
    output req_i, a_i, b_i, core_done_i, core_result_i,
    input  ack_o, done_o, result_o, err_o, busy_o,
           core_start_o, core_a_o, core_b_o, core_abort_o
  );
endinterface

// File: rtl/gcd_scheduler.sv
// Round-robin scheduler sharing one GCD core between N_REQ requesters.
// Zero operands are answered directly; otherwise the core is started and
// watched with a timeout, aborting it if it never completes.
//   clk, rst_ni : clock, asynchronous active-low reset
//   bus (slave) : req_i/a_i/b_i in, ack_o/done_o/result_o/err_o/busy_o out,
//                 core_start_o/core_a_o/core_b_o/core_abort_o to the core,
//                 core_done_i/core_result_i from the core
module gcd_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           rst_ni,
  gcd_scheduler_if.slave bus
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CAND_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CHECK, WAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               err_q, err_d;

  logic [N_REQ-1:0]   ack_d, done_d;
  logic [WIDTH-1:0]   result_d;
  logic               err_out_d, busy_d, start_d, abort_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [CAND_W-1:0]  cand;

  // First active request at or above the rr pointer, wrapping at N_REQ
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_q} + CAND_W'(i);
      if (cand >= CAND_W'(N_REQ)) cand = cand - CAND_W'(N_REQ);
      if (!pick_valid && bus.req_i[cand[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    res_d     = res_q;
    err_d     = err_q;
    ack_d     = '0;
    done_d    = '0;
    result_d  = '0;
    err_out_d = 1'b0;
    start_d   = 1'b0;
    abort_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_idx;
          op_a_d  = bus.a_i[pick_idx*WIDTH +: WIDTH];
          op_b_d  = bus.b_i[pick_idx*WIDTH +: WIDTH];
          ack_d   = N_REQ'(1) << pick_idx;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // gcd(x,0) = x and gcd(0,0) = 0, so A|B covers every zero case
        if (op_a_q == '0 || op_b_q == '0) begin
          res_d   = op_a_q | op_b_q;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Completion takes priority over a timeout in the same cycle
        if (bus.core_done_i) begin
          res_d   = bus.core_result_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          abort_d = 1'b1;
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        done_d    = N_REQ'(1) << gnt_q;
        result_d  = res_q;
        err_out_d = err_q;
        rr_d      = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      rr_q             <= '0;
      gnt_q            <= '0;
      cnt_q            <= '0;
      op_a_q           <= '0;
      op_b_q           <= '0;
      res_q            <= '0;
      err_q            <= 1'b0;
      bus.ack_o        <= '0;
      bus.done_o       <= '0;
      bus.result_o     <= '0;
      bus.err_o        <= 1'b0;
      bus.busy_o       <= 1'b0;
      bus.core_start_o <= 1'b0;
      bus.core_abort_o <= 1'b0;
    end else begin
      state_q          <= state_d;
      rr_q             <= rr_d;
      gnt_q            <= gnt_d;
      cnt_q            <= cnt_d;
      op_a_q           <= op_a_d;
      op_b_q           <= op_b_d;
      res_q            <= res_d;
      err_q            <= err_d;
      bus.ack_o        <= ack_d;
      bus.done_o       <= done_d;
      bus.result_o     <= result_d;
      bus.err_o        <= err_out_d;
      bus.busy_o       <= busy_d;
      bus.core_start_o <= start_d;
      bus.core_abort_o <= abort_d;
    end
  end

  assign bus.core_a_o = op_a_q;
  assign bus.core_b_o = op_b_q;

endmodule
